// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-lite bus types for the slave slots.
//   transfer_kind     : HTRANS encoding (IDLE/BUSY/NONSEQ/SEQ)
//   transfer_size     : HSIZE encoding for 8/16/32-bit transfers
//   transfer_response : OKAY/ERROR
//   sram_state_t      : data-phase FSM states of ahb_sram_slave
//   lane_mask()       : byte-lane enables for a transfer size and address LSBs
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } transfer_kind;

    typedef enum logic [2:0] {
        Size8  = 3'b000,
        Size16 = 3'b001,
        Size32 = 3'b010
    } transfer_size;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } transfer_response;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StDone,
        StErr1,
        StErr2
    } sram_state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            Size8:   mask = 4'b0001 << addr_lo;
            Size16:  mask = 4'b0011 << {addr_lo[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Single-port word SRAM, DEPTH_WORDS x 32, synchronous read, per-byte write enables.
//   clk   : clock
//   en    : port enable; a read when we == 0, otherwise a write of the enabled lanes
//   we    : byte-lane write enables
//   addr  : word address
//   wdata : write data
//   rdata : read data, updated only by reads and held otherwise
module ahb_sram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder for one slave slot of the bus controller.
// Accepts an address phase, runs a data phase with WAIT_STATES wait cycles, performs
// byte-lane writes and answers bad transfers with a two-cycle ERROR response.
// Optional feature macro: AHB_SRAM_WRITE_PROTECT_EN (first RO_WORDS words reject writes).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sel        : slot select from the controller decoder
//   in_trans   : transfer kind; in_write : 1 = write
//   in_addr    : byte address; in_size : transfer size
//   in_ready   : muxed bus ready; address phase is only valid when high
//   in_wdata   : write data (data phase)
//   out_rdata  : read data; out_ready : data phase complete; out_resp : OKAY/ERROR
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_WORDS    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  in_trans,
    input  logic        in_write,
    input  logic [31:0] in_addr,
    input  logic [2:0]  in_size,
    input  logic        in_ready,
    input  logic [31:0] in_wdata,
    output logic [31:0] out_rdata,
    output logic        out_ready,
    output logic        out_resp
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);

    sram_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q;
    logic [AW-1:0] word_q;
    logic [3:0]    lanes_q;

    logic [31:0]   offset;
    logic [AW-1:0] acc_word;
    logic          accept, acc_bad, bad_size, misaligned, out_of_range, wp_hit;
    logic          commit, read_issue, rd_done;

    // A write that completes while the port is busy with a read parks here and drains on
    // the next free port cycle; reads of that word merge its bytes in.
    logic          buf_valid_q;
    logic [AW-1:0] buf_word_q;
    logic [3:0]    buf_lanes_q;
    logic [31:0]   buf_data_q;
    logic          buf_load, buf_drain, hit_d, hit_q;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [31:0]   merged, rdata_hold_q;

    // ------------------------------------------------------------------ address decode
    assign offset       = in_addr - BASE_ADDR;
    assign acc_word     = offset[AW+1:2];
    assign accept       = (state_q inside {StIdle, StDone, StErr2}) & sel & in_ready & in_trans[1];
    assign bad_size     = in_size > Size32;
    assign misaligned   = ((in_size == Size16) & in_addr[0]) |
                          ((in_size == Size32) & (in_addr[1:0] != 2'b00));
    assign out_of_range = {1'b0, offset} >= SPAN_BYTES;

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    assign wp_hit = in_write & ({2'b00, offset[31:2]} < RO_WORDS);
`else
    logic unused_ro_words;
    assign unused_ro_words = ^RO_WORDS;
    assign wp_hit          = 1'b0;
`endif

    logic unused_trans_lsb;
    assign unused_trans_lsb = in_trans[0];

    assign acc_bad    = bad_size | misaligned | out_of_range | wp_hit;
    assign commit     = (state_q == StDone) & wr_q & ~rst;
    assign read_issue = accept & ~acc_bad & ~in_write & ~rst;
    assign rd_done    = (state_q == StDone) & ~wr_q;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StDone, StErr2: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (acc_bad) begin
                    state_d = StErr1;
                end else if (WAIT_STATES == 0) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    cnt_d   = WAIT_INIT;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            lanes_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= in_write;
                word_q  <= acc_word;
                lanes_q <= lane_mask(in_size, in_addr[1:0]);
            end
        end
    end

    assign out_ready = !(state_q inside {StWait, StErr1});
    assign out_resp  = (state_q inside {StErr1, StErr2}) ? RespError : RespOkay;

    // ------------------------------------------------------------------ write buffer
    assign buf_load  = commit & (read_issue | buf_valid_q);
    assign buf_drain = buf_valid_q & ~read_issue;
    // The buffered write is the one still pending after this edge, if any.
    assign hit_d     = commit ? (word_q == acc_word) : (buf_valid_q & (buf_word_q == acc_word));

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            buf_valid_q <= buf_load | (buf_valid_q & ~buf_drain);
            if (read_issue) begin
                hit_q <= hit_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_word_q  <= word_q;
            buf_lanes_q <= lanes_q;
            buf_data_q  <= in_wdata;
        end
    end

    // ------------------------------------------------------------------ array port
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = acc_word;
        mem_wdata = in_wdata;
        if (read_issue) begin
            mem_en = 1'b1;
        end else if (buf_valid_q) begin
            mem_en    = 1'b1;
            mem_we    = buf_lanes_q;
            mem_addr  = buf_word_q;
            mem_wdata = buf_data_q;
        end else if (commit) begin
            mem_en   = 1'b1;
            mem_we   = lanes_q;
            mem_addr = word_q;
        end
    end

    ahb_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // ------------------------------------------------------------------ read data
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (hit_q && buf_lanes_q[i]) begin
                merged[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_q <= 32'd0;
        end else if (rd_done) begin
            rdata_hold_q <= merged;
        end
    end

    assign out_rdata = rd_done ? merged : rdata_hold_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        sel0, sel1, sel2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        rdy0, rdy1, rdy2;
    logic        resp0, resp1, resp2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // dut0: no wait states; dut1: two wait states; dut2: first four words write-protected
    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .RO_WORDS(0)) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel0), .in_trans(trans), .in_write(write), .in_addr(addr),
        .in_size(size), .in_ready(rdy0), .in_wdata(wdata), .out_rdata(rdata0),
        .out_ready(rdy0), .out_resp(resp0));
    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .RO_WORDS(0)) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel1), .in_trans(trans), .in_write(write), .in_addr(addr),
        .in_size(size), .in_ready(rdy1), .in_wdata(wdata), .out_rdata(rdata1),
        .out_ready(rdy1), .out_resp(resp1));
    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .RO_WORDS(4)) u_dut2 (
        .clk(clk), .rst(rst), .sel(sel2), .in_trans(trans), .in_write(write), .in_addr(addr),
        .in_size(size), .in_ready(rdy2), .in_wdata(wdata), .out_rdata(rdata2),
        .out_ready(rdy2), .out_resp(resp2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata2;
    endfunction

    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic resp_of(input int d);
        return (d == 0) ? resp0 : (d == 1) ? resp1 : resp2;
    endfunction

    task automatic drive_addr(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz);
        sel0  = (d == 0);
        sel1  = (d == 1);
        sel2  = (d == 2);
        trans = TransNonseq;
        write = w;
        addr  = a;
        size  = sz;
    endtask

    task automatic drive_idle();
        sel0  = 1'b0;
        sel1  = 1'b0;
        sel2  = 1'b0;
        trans = TransIdle;
    endtask

    // One non-pipelined transfer; call and return at 1 time unit after a rising edge.
    task automatic run(input string tag, input int d, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input bit exp_err,
                       output logic [31:0] rd);
        int   cyc;
        logic first_resp;
        drive_addr(d, w, a, sz);
        @(posedge clk);
        #1;
        drive_idle();
        wdata      = wd;
        cyc        = 0;
        first_resp = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_resp = resp_of(d);
        end while (!rdy_of(d) && cyc < 20);
        rd = rdata_of(d);
        check_eq({tag, ".cycles"}, cyc, exp_err ? 2 : ((d == 1) ? 3 : 1));
        check_eq({tag, ".resp"}, {31'd0, resp_of(d)}, {31'd0, exp_err});
        if (exp_err) check_eq({tag, ".resp_first"}, {31'd0, first_resp}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Write on dut0 immediately followed by a read address phase, no idle cycle between.
    task automatic pipe_wr_rd(input string tag, input logic [31:0] aw, input logic [2:0] sz,
                              input logic [31:0] wd, input logic [31:0] ar,
                              input logic [31:0] exp);
        drive_addr(0, 1'b1, aw, sz);
        @(posedge clk);
        #1;
        wdata = wd;
        drive_addr(0, 1'b0, ar, Size32);
        @(negedge clk);
        check_eq({tag, ".wr_ready"}, {31'd0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check_eq({tag, ".rd_ready"}, {31'd0, rdy0}, 32'd1);
        check_eq({tag, ".rdata"}, rdata0, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        rst   = 1'b1;
        wdata = 32'd0;
        write = 1'b0;
        addr  = 32'd0;
        size  = Size32;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst.ready0", {31'd0, rdy0}, 32'd1);
        check_eq("rst.resp0", {31'd0, resp0}, 32'd0);
        check_eq("rst.rdata0", rdata0, 32'd0);
        check_eq("rst.ready1", {31'd0, rdy1}, 32'd1);
        @(posedge clk);
        #1;

        // 1: zero wait states, word write then read
        run("t1.wr", 0, 1'b1, BASE + 32'h8, Size32, 32'hDEAD_BEEF, 1'b0, rd);
        run("t1.rd", 0, 1'b0, BASE + 32'h8, Size32, 32'd0, 1'b0, rd);
        check_eq("t1.rdata", rd, 32'hDEAD_BEEF);

        // 2: two wait states
        run("t2.wr", 1, 1'b1, BASE + 32'h4, Size32, 32'h1234_5678, 1'b0, rd);
        run("t2.rd", 1, 1'b0, BASE + 32'h4, Size32, 32'd0, 1'b0, rd);
        check_eq("t2.rdata", rd, 32'h1234_5678);

        // 3: byte lane write, misaligned halfword
        run("t3.clr", 0, 1'b1, BASE + 32'hC, Size32, 32'h0000_0000, 1'b0, rd);
        run("t3.byte", 0, 1'b1, BASE + 32'hD, Size8, 32'h0000_A500, 1'b0, rd);
        run("t3.rd", 0, 1'b0, BASE + 32'hC, Size32, 32'd0, 1'b0, rd);
        check_eq("t3.rdata", rd, 32'h0000_A500);
        run("t3.half_mis", 0, 1'b0, BASE + 32'hD, Size16, 32'd0, 1'b1, rd);
        check_eq("t3.rdata_held", rdata0, 32'h0000_A500);
        run("t3.half_ok", 0, 1'b1, BASE + 32'hE, Size16, 32'h3C3C_0000, 1'b0, rd);
        run("t3.rd2", 0, 1'b0, BASE + 32'hC, Size32, 32'd0, 1'b0, rd);
        check_eq("t3.rdata2", rd, 32'h3C3C_A500);

        // 4: out of range (wraps onto word 5 if not blocked), bad size, misaligned word
        run("t4.wr5", 0, 1'b1, BASE + 32'd20, Size32, 32'h5555_5555, 1'b0, rd);
        run("t4.wr_oor", 0, 1'b1, BASE + 32'd84, Size32, 32'hFFFF_FFFF, 1'b1, rd);
        run("t4.rd_oor", 0, 1'b0, BASE + DEPTH * 4, Size32, 32'd0, 1'b1, rd);
        run("t4.rd5", 0, 1'b0, BASE + 32'd20, Size32, 32'd0, 1'b0, rd);
        check_eq("t4.unchanged", rd, 32'h5555_5555);
        run("t4.below_base", 0, 1'b0, BASE - 32'd4, Size32, 32'd0, 1'b1, rd);
        run("t4.size64", 0, 1'b0, BASE, 3'b011, 32'd0, 1'b1, rd);
        run("t4.word_mis", 0, 1'b0, BASE + 32'd2, Size32, 32'd0, 1'b1, rd);

        // 5: back-to-back write/read of word 3, then reset during a wait state
        pipe_wr_rd("t5.full", BASE + 32'hC, Size32, 32'hCAFE_F00D, BASE + 32'hC, 32'hCAFE_F00D);
        pipe_wr_rd("t5.byte", BASE + 32'hF, Size8, 32'h7700_0000, BASE + 32'hC, 32'h77FE_F00D);
        pipe_wr_rd("t5.other", BASE + 32'h8, Size16, 32'h0000_1111, BASE + 32'hC,
                   32'h77FE_F00D);
        run("t5.rd3", 0, 1'b0, BASE + 32'hC, Size32, 32'd0, 1'b0, rd);
        check_eq("t5.rd3_data", rd, 32'h77FE_F00D);
        run("t5.rd2", 0, 1'b0, BASE + 32'h8, Size32, 32'd0, 1'b0, rd);
        check_eq("t5.rd2_data", rd, 32'hDEAD_1111);

        run("t5.pre", 1, 1'b1, BASE + 32'h8, Size32, 32'h0BAD_F00D, 1'b0, rd);
        drive_addr(1, 1'b1, BASE + 32'h8, Size32);
        @(posedge clk);
        #1;
        drive_idle();
        wdata = 32'hBADB_AD00;
        @(negedge clk);
        check_eq("t5.wait_ready", {31'd0, rdy1}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5.rst_ready", {31'd0, rdy1}, 32'd1);
        check_eq("t5.rst_resp", {31'd0, resp1}, 32'd0);
        @(posedge clk);
        #1;
        run("t5.after_rst", 1, 1'b0, BASE + 32'h8, Size32, 32'd0, 1'b0, rd);
        check_eq("t5.no_write", rd, 32'h0BAD_F00D);

        // 6: write protection of the first four words
`ifdef AHB_SRAM_WRITE_PROTECT_EN
        run("t6.wr_ro", 2, 1'b1, BASE, Size32, 32'hA5A5_5A5A, 1'b1, rd);
        run("t6.rd_ro", 2, 1'b0, BASE, Size32, 32'd0, 1'b0, rd);
        check_eq("t6.ro_unchanged", {31'd0, rd == 32'hA5A5_5A5A}, 32'd0);
        run("t6.wr_ro_byte", 2, 1'b1, BASE + 32'hF, Size8, 32'h1100_0000, 1'b1, rd);
`else
        run("t6.wr0", 2, 1'b1, BASE, Size32, 32'hA5A5_5A5A, 1'b0, rd);
        run("t6.rd0", 2, 1'b0, BASE, Size32, 32'd0, 1'b0, rd);
        check_eq("t6.rdata0", rd, 32'hA5A5_5A5A);
`endif
        run("t6.wr16", 2, 1'b1, BASE + 32'd16, Size32, 32'h0F1E_2D3C, 1'b0, rd);
        run("t6.rd16", 2, 1'b0, BASE + 32'd16, Size32, 32'd0, 1'b0, rd);
        check_eq("t6.rdata16", rd, 32'h0F1E_2D3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
